// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// grant vectors and the default watchdog limit.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter: counts strobed-but-unacknowledged cycles and raises a one-cycle
// expire pulse the cycle after the count sits at TIMEOUT. TIMEOUT=0 disables it.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic expire_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, stb_i, ack_i, clr_i};
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);

      logic [CW-1:0] count_q, count_d;
      logic          expire_q, expire_d;
      logic          at_limit;

      assign at_limit = (count_q == CW'(TIMEOUT));

      // An ack in the limit cycle, or a grant change, suppresses the error.
      always_comb begin
        expire_d = at_limit & stb_i & ~ack_i & ~clr_i;
        if (clr_i || ack_i || !stb_i || at_limit) count_d = '0;
        else                                      count_d = count_q + CW'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q  <= '0;
          expire_q <= 1'b0;
        end else begin
          count_q  <= count_d;
          expire_q <= expire_d;
        end
      end

      assign expire_o = expire_q;
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant with bus lock while
// the owner holds cyc, and a watchdog that terminates unacknowledged transfers.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_data_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_data_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_data_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_data_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_data_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       expire;
  logic       state_change;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // On a tie in IDLE the master that did not hold the bus last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase

    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == GNT0) last_d = 1'b0;
      if (state_d == GNT1) last_d = 1'b1;
    end
  end

  assign state_change = (state_d != state_q);

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .stb_i    (s_stb_o),
    .ack_i    (s_ack_i),
    .clr_i    (state_change),
    .expire_o (expire)
  );

  // Slave side is decoded purely from the registered state so reset clears it at once.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = GNT_NONE;
    unique case (state_q)
      GNT0: begin
        gnt_o    = GNT_M0;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~expire;
        s_stb_o  = m0_stb_i & ~expire;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = expire;
      end
      GNT1: begin
        gnt_o    = GNT_M1;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~expire;
        s_stb_o  = m1_stb_i & ~expire;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = expire;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Randomized bench for wb_arbiter_2m, checked every cycle against a behavioural
// model of owner / round-robin / stall-count rules, plus directed corner cases.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0] gnt_o;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), who had it last, stall count
  // and whether an error is due this cycle.
  int own, last, cnt;
  bit errp;

  // Observed values of the most recent step, used by the directed tests.
  logic obs_stb, obs_err0, obs_ack0;
  logic [1:0] obs_gnt;

  task automatic model_reset();
    own = -1; last = 1; cnt = 0; errp = 0;
  endtask

  task automatic step();
    logic c[2], s[2], we[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    logic [DW/8-1:0] sl[2];
    logic e_stb, e_cyc, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW/8-1:0] e_sel;
    logic [1:0] e_gnt;
    int nown, ncnt;
    bit chg, nerr;
    @(negedge clk);
    c[0] = m0_cyc_i; c[1] = m1_cyc_i; s[0] = m0_stb_i; s[1] = m1_stb_i;
    we[0] = m0_we_i; we[1] = m1_we_i; a[0] = m0_addr_i; a[1] = m1_addr_i;
    d[0] = m0_data_i; d[1] = m1_data_i; sl[0] = m0_sel_i; sl[1] = m1_sel_i;
    e_stb = 0; e_cyc = 0; e_we = 0; e_addr = '0; e_data = '0; e_sel = '0; e_gnt = 2'b00;
    if (own >= 0) begin
      e_gnt  = (own == 0) ? 2'b01 : 2'b10;
      e_cyc  = c[own] && !errp;
      e_stb  = s[own] && !errp;
      e_we   = we[own];
      e_addr = a[own];
      e_data = d[own];
      e_sel  = sl[own];
    end
    check_eq("gnt", 64'(gnt_o), 64'(e_gnt));
    check_eq("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
    check_eq("s_stb", 64'(s_stb_o), 64'(e_stb));
    check_eq("s_we", 64'(s_we_o), 64'(e_we));
    check_eq("s_addr", 64'(s_addr_o), 64'(e_addr));
    check_eq("s_data", 64'(s_data_o), 64'(e_data));
    check_eq("s_sel", 64'(s_sel_o), 64'(e_sel));
    check_eq("m0_ack", 64'(m0_ack_o), 64'(s_ack_i && own == 0 && s[0]));
    check_eq("m1_ack", 64'(m1_ack_o), 64'(s_ack_i && own == 1 && s[1]));
    check_eq("m0_err", 64'(m0_err_o), 64'(errp && own == 0));
    check_eq("m1_err", 64'(m1_err_o), 64'(errp && own == 1));
    check_eq("m0_rdata", 64'(m0_data_o), 64'(s_data_i));
    check_eq("m1_rdata", 64'(m1_data_o), 64'(s_data_i));
    obs_stb = s_stb_o; obs_err0 = m0_err_o; obs_ack0 = m0_ack_o; obs_gnt = gnt_o;

    nown = own;
    if (own < 0) begin
      if (c[0] && c[1]) nown = (last == 1) ? 0 : 1;
      else if (c[0])    nown = 0;
      else if (c[1])    nown = 1;
    end else if (!c[own]) begin
      nown = c[1-own] ? 1 - own : -1;
    end
    chg  = (nown != own);
    nerr = (cnt == TO) && e_stb && !s_ack_i && !chg;
    ncnt = (chg || s_ack_i || !e_stb || cnt == TO) ? 0 : cnt + 1;

    @(posedge clk);
    if (chg && nown >= 0) last = nown;
    own = nown; cnt = ncnt; errp = nerr;
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; the bus must drop without a clock edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    check_eq("rst_s_stb", 64'(s_stb_o), 64'd0);
    check_eq("rst_gnt", 64'(gnt_o), 64'd0);
    check_eq("rst_m0_ack", 64'(m0_ack_o | m0_err_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
  endtask

  int rem0, rem1, i0, i1, errs;
  int ack_pct, stb_pct, max_burst;

  initial begin
    rst = 1'b1;
    m0_addr_i = 32'h1000_0040; m0_data_i = 32'h1111_2222; m0_sel_i = 4'hF; m0_we_i = 1;
    m1_addr_i = 32'h2000_0080; m1_data_i = 32'h3333_4444; m1_sel_i = 4'h3; m1_we_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 0; m1_stb_i = 0;
    s_data_i = 32'h0; s_ack_i = 0;
    model_reset();

    // Reset held with m0 requesting: everything idle.
    #12;
    check_eq("por_gnt", 64'(gnt_o), 64'd0);
    check_eq("por_s_cyc", 64'(s_cyc_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();
    check_eq("first_gnt", 64'(obs_gnt), 64'd1);

    // Reset mid-transfer.
    do_reset();

    // Simultaneous request: m0 first, handover to m1 without bubble, m0 waits.
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(); step();
    check_eq("tie_gnt_m0", 64'(obs_gnt), 64'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step(); step();
    check_eq("handover_m1", 64'(obs_gnt), 64'd2);
    m0_cyc_i = 1; m0_stb_i = 1;
    // Locked burst: m1 gets 4 acked beats while m0 requests.
    for (int k = 0; k < 4; k++) begin
      s_ack_i = 1;
      step();
      check_eq("lock_gnt", 64'(obs_gnt), 64'd2);
      check_eq("lock_m0_ack", 64'(obs_ack0), 64'd0);
    end
    // Read data returned to m1.
    s_data_i = 32'hCAFE_F00D;
    step();
    check_eq("rd_m1_data", 64'(m1_data_o), 64'hCAFE_F00D);
    check_eq("rd_m1_ack", 64'(m1_ack_o), 64'd1);
    check_eq("rd_m0_ack", 64'(m0_ack_o), 64'd0);
    s_ack_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;
    step(); step();
    check_eq("m0_after_m1", 64'(obs_gnt), 64'd1);
    idle_inputs();
    step();
    do_reset();

    // Slave never acks: err 9 cycles after stb rise.
    m0_cyc_i = 1; m0_stb_i = 1;
    i0 = -1; i1 = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_stb && i0 < 0) i0 = k;
      if (obs_err0 && i1 < 0) i1 = k;
    end
    check_eq("timeout_delay", 64'(i1 - i0), 64'd9);
    idle_inputs();
    step();
    do_reset();

    // Ack on the 8th stalled cycle wins over the watchdog.
    m0_cyc_i = 1; m0_stb_i = 1;
    i0 = -1; errs = 0;
    for (int k = 0; k < 16; k++) begin
      s_ack_i = (i0 >= 0 && k == i0 + 7);
      step();
      if (obs_stb && i0 < 0) i0 = k;
      if (i0 >= 0 && k == i0 + 7) check_eq("edge_ack", 64'(obs_ack0), 64'd1);
      if (i0 >= 0 && k <= i0 + 8) errs += int'(obs_err0);
    end
    check_eq("edge_no_err", 64'(errs), 64'd0);
    idle_inputs();
    step();

    // Randomized phases: normal acks, dead slave, sparse acks.
    rem0 = 0; rem1 = 0;
    for (int ph = 0; ph < 3; ph++) begin
      ack_pct   = (ph == 0) ? 60 : (ph == 1) ? 0 : 20;
      stb_pct   = (ph == 1) ? 100 : 70;
      max_burst = (ph == 1) ? 25 : 12;
      for (int k = 0; k < 400; k++) begin
        if (rem0 == 0 && $urandom_range(0, 99) < 30) rem0 = $urandom_range(1, max_burst);
        if (rem1 == 0 && $urandom_range(0, 99) < 30) rem1 = $urandom_range(1, max_burst);
        m0_cyc_i = (rem0 > 0);
        m1_cyc_i = (rem1 > 0);
        m0_stb_i = m0_cyc_i && ($urandom_range(0, 99) < stb_pct);
        m1_stb_i = m1_cyc_i && ($urandom_range(0, 99) < stb_pct);
        m0_addr_i = $urandom; m1_addr_i = $urandom;
        m0_data_i = $urandom; m1_data_i = $urandom;
        m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
        m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
        s_data_i = $urandom;
        s_ack_i = ($urandom_range(0, 99) < ack_pct);
        step();
        if (rem0 > 0) rem0--;
        if (rem1 > 0) rem1--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
